// File: rtl/int_arbiter.sv
// int_arbiter: edge-captured, maskable priority interrupt arbiter.
// Optional round-robin search: define INT_ARB_ROUND_ROBIN_EN.
module int_arbiter #(
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               int_en,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_din,
  output logic               on_int,
  output logic               vec_oe,
  output logic [31:0]        vec_data,
  output logic [NUM_SRC-1:0] src_ack,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  localparam int W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACK,
    INSVC
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [W-1:0]       win;
  logic [W-1:0]       win_nx;
  logic               ack_fire;

  assign elig     = pending & ~mask;
  assign ack_fire = (state == PEND) && int_en && int_ack;
  assign clr      = ack_fire
                  ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << win)
                  : '0;

  assign vec_oe   = ack_fire;
  assign src_ack  = clr;
  assign vec_data = ack_fire ? VEC_BASE + 32'(win) : VEC_BASE;

`ifdef INT_ARB_ROUND_ROBIN_EN
  logic [W-1:0]         ptr;
  logic [2*NUM_SRC-1:0] rot;

  assign rot = {elig, elig} >> ptr;

  // Round-robin pick: first eligible source at or after ptr, wrapping.
  always_comb begin
    logic found;
    int   sum;
    win_nx = '0;
    found  = 1'b0;
    sum    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        win_nx = W'(sum);
      end
    end
  end

  // Pointer moves just past each acknowledged winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (ack_fire) begin
      ptr <= (int'(win) == NUM_SRC - 1) ? '0 : win + 1'b1;
    end
  end
`else
  // Fixed priority pick: lowest eligible index wins.
  always_comb begin
    win_nx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (elig[k]) win_nx = W'(k);
    end
  end
`endif

  // Next-state decode of the request/ack/service handshake.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|elig && int_en) state_nx = PEND;
      PEND: begin
        if (!int_en)      state_nx = IDLE;
        else if (int_ack) state_nx = ACK;
      end
      ACK:     if (!int_ack) state_nx = INSVC;
      INSVC:   if (eoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Edge detect, pending set/clear (set wins) and mask load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q   <= '0;
      edge_q  <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      irq_q   <= irq;
      edge_q  <= irq & ~irq_q;
      pending <= (pending & ~clr) | edge_q;
      if (mask_we) mask <= mask_din;
    end
  end

  // State, frozen winner and registered request/service flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      win        <= '0;
      on_int     <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == PEND) win <= win_nx;
      on_int     <= (state_nx == PEND);
      in_service <= (state_nx == ACK) || (state_nx == INSVC);
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: scoreboard bench for int_arbiter.
// Directed scenarios followed by randomized traffic.
module tb_int_arbiter;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_0010;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq;
  logic         int_en;
  logic         int_ack;
  logic         eoi;
  logic         mask_we;
  logic [N-1:0] mask_din;
  logic         on_int;
  logic         vec_oe;
  logic [31:0]  vec_data;
  logic [N-1:0] src_ack;
  logic [N-1:0] pending;
  logic         in_service;

  int_arbiter #(.NUM_SRC(N), .VEC_BASE(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .irq(irq),
    .int_en(int_en),
    .int_ack(int_ack),
    .eoi(eoi),
    .mask_we(mask_we),
    .mask_din(mask_din),
    .on_int(on_int),
    .vec_oe(vec_oe),
    .vec_data(vec_data),
    .src_ack(src_ack),
    .pending(pending),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  v;
    logic [N-1:0] a;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Reference model: handler phase, pending set, mask, ptr.
  localparam int P_IDLE = 0;
  localparam int P_PEND = 1;
  localparam int P_ACK  = 2;
  localparam int P_SVC  = 3;

  int           ph;
  int           m_win;
  int           m_ptr;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_edge;
  logic         exp_fire;
  logic         exp_on_int;
  logic         exp_insvc;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] el);
    for (int k = 0; k < N; k++) begin
`ifdef INT_ARB_ROUND_ROBIN_EN
      int idx = (m_ptr + k) % N;
`else
      int idx = k;
`endif
      if (el[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    ph         = P_IDLE;
    m_win      = 0;
    m_ptr      = 0;
    m_pend     = '0;
    m_mask     = '0;
    m_prev     = '0;
    m_edge     = '0;
    exp_fire   = 1'b0;
    exp_on_int = 1'b0;
    exp_insvc  = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    logic [N-1:0] clr;
    int           nph;
    elig = m_pend & ~m_mask;
    clr  = '0;
    nph  = ph;
    case (ph)
      P_IDLE: if (elig != 0 && int_en) begin
        nph   = P_PEND;
        m_win = pick(elig);
      end
      P_PEND: if (!int_en) nph = P_IDLE;
        else if (int_ack) begin
          nph        = P_ACK;
          clr[m_win] = 1'b1;
          m_ptr      = (m_win + 1) % N;
        end
      P_ACK: if (!int_ack) nph = P_SVC;
      default: if (eoi) nph = P_IDLE;
    endcase
    m_pend = (m_pend & ~clr) | m_edge;
    m_edge = irq & ~m_prev;
    m_prev = irq;
    if (mask_we) m_mask = mask_din;
    ph         = nph;
    exp_on_int = (ph == P_PEND);
    exp_insvc  = (ph == P_ACK) || (ph == P_SVC);
  endtask

  // Stimulus side: predict the ack response for this cycle's inputs.
  task automatic arm();
    exp_t e;
    exp_fire = (ph == P_PEND) && int_en && int_ack;
    if (exp_fire) begin
      e.v = BASE + 32'(m_win);
      e.a = N'(1) << m_win;
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    arm();
    tick();
  endtask

  task automatic wait_on_int(input string nm);
    int i;
    for (i = 0; i < 12 && !on_int; i++) cyc();
    if (!on_int) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: on_int timeout got 0 expected 1", nm);
    end
  endtask

  task automatic service();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    cyc();
    eoi = 1'b1;
    cyc();
    eoi = 1'b0;
  endtask

  // Monitor: compare outputs and pop ack responses away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      check("on_int", on_int, exp_on_int);
      check("in_service", in_service, exp_insvc);
      check("pending", pending, m_pend);
      check("vec_oe", vec_oe, exp_fire);
      if (vec_oe || exp_fire) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: vec_oe with no expected ack");
        end else begin
          e = q.pop_front();
          check("vec_data", vec_data, e.v);
          check("src_ack", src_ack, e.a);
        end
      end else begin
        check("src_ack_idle", src_ack, '0);
        check("vec_idle", vec_data, BASE);
      end
    end
  end

  logic [31:0] first_v;
  logic [31:0] second_v;

  initial begin
`ifdef INT_ARB_ROUND_ROBIN_EN
    first_v  = 32'h12;
    second_v = 32'h10;
`else
    first_v  = 32'h10;
    second_v = 32'h12;
`endif
    rst      = 1'b0;
    irq      = 4'b0011;
    int_en   = 1'b1;
    int_ack  = 1'b0;
    eoi      = 1'b0;
    mask_we  = 1'b0;
    mask_din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_on_int", on_int, 0);
    check("rst_pending", pending, 0);
    check("rst_vec_oe", vec_oe, 0);
    check("rst_src_ack", src_ack, 0);
    check("rst_insvc", in_service, 0);
    check("rst_vec_data", vec_data, BASE);
    irq = '0;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;
    repeat (3) cyc();

    // single source: 3-cycle latency, same-cycle vector
    irq = 4'b0010;
    cyc();
    check("lat1_on_int", on_int, 0);
    cyc();
    check("lat2_on_int", on_int, 0);
    check("lat2_pending", pending, 4'b0010);
    cyc();
    check("lat3_on_int", on_int, 1);
    int_ack = 1'b1;
    arm();
    #1;
    check("s_vec_oe", vec_oe, 1);
    check("s_vec_data", vec_data, 32'h11);
    check("s_src_ack", src_ack, 4'b0010);
    tick();
    check("s_pend_clr", pending, 0);
    check("s_insvc", in_service, 1);
    repeat (3) cyc();
    int_ack = 1'b0;
    cyc();
    eoi = 1'b1;
    cyc();
    eoi = 1'b0;
    check("s_eoi", in_service, 0);

    // simultaneous sources 0 and 2
    irq = 4'b0101;
    wait_on_int("sim1");
    int_ack = 1'b1;
    arm();
    #1;
    check("sim_first", vec_data, first_v);
    tick();
    int_ack = 1'b0;
    cyc();
    eoi = 1'b1;
    cyc();
    eoi = 1'b0;
    wait_on_int("sim2");
    int_ack = 1'b1;
    arm();
    #1;
    check("sim_second", vec_data, second_v);
    tick();
    int_ack = 1'b0;
    cyc();
    eoi = 1'b1;
    cyc();
    eoi = 1'b0;

    // masking and IE gating
    irq = '0;
    mask_we  = 1'b1;
    mask_din = 4'b0001;
    cyc();
    mask_we = 1'b0;
    irq = 4'b0001;
    repeat (5) cyc();
    check("mask_on_int", on_int, 0);
    check("mask_pending", pending, 4'b0001);
    mask_we  = 1'b1;
    mask_din = '0;
    cyc();
    mask_we = 1'b0;
    cyc();
    check("unmask_on_int", on_int, 1);
    int_en = 1'b0;
    cyc();
    check("ie_off", on_int, 0);
    int_en = 1'b1;
    cyc();
    check("ie_on", on_int, 1);
    service();

    // overlap: new edge during service waits for eoi
    irq = 4'b0010;
    wait_on_int("ovl");
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    cyc();
    irq = 4'b1010;
    repeat (4) cyc();
    check("ovl_pend3", pending & 4'b1000, 4'b1000);
    check("ovl_on_int", on_int, 0);
    eoi = 1'b1;
    cyc();
    eoi = 1'b0;
    check("ovl_eoi1", on_int, 0);
    cyc();
    check("ovl_eoi2", on_int, 1);
    service();

    // abort: reset while in ACK
    irq = '0;
    cyc();
    irq = 4'b0100;
    wait_on_int("abort");
    int_ack = 1'b1;
    cyc();
    check("abort_pre", in_service, 1);
    chk_en = 1'b0;
    rst    = 1'b0;
    irq    = '0;
    #1;
    check("abort_insvc", in_service, 0);
    check("abort_src_ack", src_ack, 0);
    check("abort_on_int", on_int, 0);
    check("abort_vec_oe", vec_oe, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst    = 1'b1;
    chk_en = 1'b1;
    repeat (2) cyc();
    int_ack = 1'b0;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      irq      = irq ^ (4'($urandom_range(0, 15)) &
                        4'($urandom_range(0, 15)));
      int_en   = ($urandom_range(0, 7) != 0);
      int_ack  = int_en && ($urandom_range(0, 2) == 0);
      eoi      = ($urandom_range(0, 3) == 0);
      mask_we  = ($urandom_range(0, 15) == 0);
      mask_din = 4'($urandom_range(0, 15));
      cyc();
    end
    int_ack = 1'b0;
    mask_we = 1'b0;
    eoi     = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
# int_arbiter

Priority interrupt arbiter between the peripheral devices (timer, distance tracker, future devices) and the processor's microcontroller. It captures device interrupt edges into a pending register, applies a software mask, and presents a single registered `on_int` request gated by the processor's IE. On the microcode `int_ack` it selects one winner, drives that winner's vector onto the device data bus and returns a one-hot acknowledge. It then holds the winner in service until end-of-interrupt, replacing the ad-hoc daisy chain and the shared tri-state `OnInt` wiring.

## Interface
- `NUM_SRC`, 4: number of interrupt sources, 2..16.
- `VEC_BASE`, 32'h0000_0010: vector for source 0; source i returns `VEC_BASE + i`.
- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-low.
- `irq` input NUM_SRC: device requests, level, synchronous to `clk`; bit 0 = timer, bit 1 = distance tracker.
- `int_en` input 1: processor IE flag.
- `int_ack` input 1: microcode IntAck.
- `eoi` input 1: end-of-interrupt strobe, one cycle.
- `mask_we` input 1: mask write strobe.
- `mask_din` input NUM_SRC: new mask; 1 = source masked.
- `on_int` output 1: interrupt request to the microcontroller.
- `vec_oe` output 1: bus drive enable; the top level tri-states `vec_data` onto the device bus.
- `vec_data` output 32: vector of the current winner.
- `src_ack` output NUM_SRC: one-hot acknowledge to the winning device.
- `pending` output NUM_SRC: pending register.
- `in_service` output 1: a handler is active.

## Operation
- Edge capture: `irq_q` is the `irq` delayed one cycle. A rising edge (`irq & ~irq_q`) sets `pending[i]`. Acknowledge clears `pending[winner]`. When set and clear hit the same bit in the same cycle, set wins.
- Mask: `mask_we` loads the mask at the clock edge. Masked bits keep pending state but do not arbitrate. Eligible = `pending & ~mask`.
- Winner select: fixed priority by default, lowest index highest. The winner is latched in a register `win` when the FSM enters PEND and is frozen until the FSM returns to IDLE.
- FSM states: IDLE, PEND, ACK, INSVC.
  - IDLE -> PEND when eligible is nonzero and `int_en` is 1; latch `win`.
  - PEND -> IDLE when `int_en` is 0; no pending bit changes.
  - PEND -> ACK when `int_ack` is 1. In that same cycle `vec_oe`=1, `vec_data`=`VEC_BASE+win`, and `src_ack[win]`=1 (Mealy). `pending[win]` clears at the edge.
  - ACK -> INSVC when `int_ack` is 0. While in ACK, `vec_oe` and `src_ack` stay 0.
  - INSVC -> IDLE when `eoi` is 1.
- `on_int` is 1 in PEND only, registered from the next-state decode. `in_service` is 1 in ACK and INSVC.
- No nesting: new edges only accumulate in `pending` during ACK and INSVC.
- Masking the winner while in PEND does not cancel it; the frozen winner is still acknowledged.
- `int_ack` outside PEND and `eoi` outside INSVC are ignored.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `pending`=0, mask=0, `irq_q`=0, `win`=0, round-robin pointer=0, `on_int`=0, `vec_oe`=0, `src_ack`=0, `in_service`=0.
  - `vec_data` is `VEC_BASE` while not driven.
  - Reset mid-handshake aborts immediately; no `src_ack` is emitted.
- Latency from a rising edge on `irq[i]` to `on_int`=1 is 3 cycles: edge detect, pending set, IDLE->PEND registered.
- `int_ack` -> vector and acknowledge: same cycle, combinational.
- After `eoi`, the next `on_int` rises 2 cycles later if any eligible bit is set.
- `int_ack` held high for several cycles produces exactly one `src_ack` pulse.

## Configuration
- `INT_ARB_ROUND_ROBIN_EN` defined:
  - The search starts at a pointer register and wraps modulo `NUM_SRC`.
  - On each acknowledge the pointer loads `win+1`, wrapping to 0 after `NUM_SRC-1`.
- Not defined: fixed priority, index 0 highest; the pointer register is not built.

## Test plan
- Reset: drive `irq`=4'b0011 with `rst`=0 -> `on_int`=0, `pending`=0, `vec_oe`=0; after release, all outputs stay at reset values until an edge occurs.
- Single source: edge on `irq[1]` with `int_en`=1 -> `on_int`=1 three cycles later. Then `int_ack`=1 -> same-cycle `vec_data`=32'h11, `vec_oe`=1, `src_ack`=4'b0010; next cycle `pending`=0.
- Simultaneous sources: edges on `irq[0]` and `irq[2]` in one cycle.
  - Fixed priority: first vector 32'h10, second 32'h12 after `eoi`.
  - With `INT_ARB_ROUND_ROBIN_EN`: after a prior ack of source 0, the order becomes 2 then 0.
- Masking and gating:
  - mask=4'b0001 with an edge on `irq[0]` -> no `on_int`, `pending[0]`=1; clearing the mask raises `on_int`.
  - `int_en` dropped in PEND -> `on_int`=0, and it returns to 1 when `int_en` is restored.
- Overlap: a new edge on `irq[3]` during INSVC -> `pending[3]`=1 with `on_int`=0 until `eoi`, then `on_int`=1 after 2 cycles.
- Abort: `rst`=0 asserted in ACK -> next sample shows state IDLE, `src_ack`=0, `in_service`=0.
